// File: rtl/sram_like_arb_pkg.sv
// Shared definitions for the sram-like arbiter: arbitration encodings,
// bus field widths, grant-lock states and a constant clog2 helper.
package sram_like_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;
  localparam int STRB_W = 4;

  typedef enum logic {
    GS_FREE   = 1'b0,
    GS_LOCKED = 1'b1
  } grant_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_like_idfifo.sv
// In-order ID FIFO: remembers which master owns each accepted, not yet
// answered transaction. Push is ignored when full, pop when empty.
module sram_like_idfifo
  import sram_like_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sram_like_arb.sv
// N-to-1 sram-like bus arbiter with zero added latency. Responses come back
// in acceptance order and are routed to their owner through the ID FIFO.
module sram_like_arb
  import sram_like_arb_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int MAX_OUTST = 4,
  parameter int ARB_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_M-1:0]      m_req,
  input  logic [NUM_M-1:0]      m_wr,
  input  logic [2*NUM_M-1:0]    m_size,
  input  logic [4*NUM_M-1:0]    m_wstrb,
  input  logic [32*NUM_M-1:0]   m_addr,
  input  logic [32*NUM_M-1:0]   m_wdata,
  output logic [NUM_M-1:0]      m_addr_ok,
  output logic [NUM_M-1:0]      m_data_ok,
  output logic [32*NUM_M-1:0]   m_rdata,
  output logic                  s_req,
  output logic                  s_wr,
  output logic [1:0]            s_size,
  output logic [3:0]            s_wstrb,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  input  logic                  s_addr_ok,
  input  logic                  s_data_ok,
  input  logic [31:0]           s_rdata,
  output logic                  err
);

  localparam int IDX_W = clog2(NUM_M);

  grant_state_e     gs_q, gs_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             rr_vld_q, rr_vld_d;
  logic             err_q, err_d;
  logic             live_q, live_d;
  logic [IDX_W-1:0] win, cand, grant, head;
  int               rr_start;
  logic             found, active, push, pop, fifo_full, fifo_empty;

  // Round-robin search starts after the last accepted master; before any
  // acceptance since reset it starts at master 0.
  always_comb begin
    win      = '0;
    cand     = '0;
    found    = 1'b0;
    rr_start = 0;
    if (ARB_MODE == ARB_RR) begin
      rr_start = rr_vld_q ? (int'(rr_q) + 1) % NUM_M : 0;
      for (int k = 0; k < NUM_M; k++) begin
        cand = IDX_W'((rr_start + k) % NUM_M);
        if (!found && m_req[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_M - 1; k >= 0; k--) begin
        cand = IDX_W'(k);
        if (m_req[cand]) win = cand;
      end
    end
  end

  always_comb begin
    gs_d       = gs_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    rr_vld_d   = rr_vld_q;
    err_d      = err_q;
    live_d     = 1'b1;
    m_addr_ok  = '0;
    m_data_ok  = '0;
    grant      = (gs_q == GS_LOCKED) ? lock_idx_q : win;
    active     = live_q & resetn;
    s_req      = active & (|m_req) & m_req[grant] & ~fifo_full;
    push       = s_req & s_addr_ok;
    pop        = active & s_data_ok & ~fifo_empty;
    if (push) begin
      gs_d           = GS_FREE;
      rr_d           = grant;
      rr_vld_d       = 1'b1;
      m_addr_ok[grant] = 1'b1;
    end else if (s_req) begin
      gs_d       = GS_LOCKED;
      lock_idx_d = grant;
    end
    if (pop) m_data_ok[head] = 1'b1;
    if (s_data_ok && fifo_empty) err_d = 1'b1;
  end

  assign s_wr    = m_wr[grant];
  assign s_size  = m_size[grant*SIZE_W +: SIZE_W];
  assign s_wstrb = m_wstrb[grant*STRB_W +: STRB_W];
  assign s_addr  = m_addr[grant*ADDR_W +: ADDR_W];
  assign s_wdata = m_wdata[grant*DATA_W +: DATA_W];
  assign m_rdata = {NUM_M{s_rdata}};
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      gs_q       <= GS_FREE;
      lock_idx_q <= '0;
      rr_q       <= '0;
      rr_vld_q   <= 1'b0;
      err_q      <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      gs_q       <= gs_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
      rr_vld_q   <= rr_vld_d;
      err_q      <= err_d;
      live_q     <= live_d;
    end
  end

  sram_like_idfifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_idfifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (grant),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );

endmodule

// File: tb/tb_sram_like_arb.sv
// Bench for sram_like_arb: a 2-master fixed-priority instance driven from a
// vector table and short sequences, and a 3-master round-robin instance
// checked against a queue-based reference model under random traffic.
module tb_sram_like_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Fixed-priority instance (2 masters)
  logic        resetn_f;
  logic [1:0]  m_req_f, m_wr_f, m_addr_ok_f, m_data_ok_f;
  logic [3:0]  m_size_f;
  logic [7:0]  m_wstrb_f;
  logic [63:0] m_addr_f, m_wdata_f, m_rdata_f;
  logic        s_req_f, s_wr_f, s_addr_ok_f, s_data_ok_f, err_f;
  logic [1:0]  s_size_f;
  logic [3:0]  s_wstrb_f;
  logic [31:0] s_addr_f, s_wdata_f, s_rdata_f;

  // Round-robin instance (3 masters)
  logic        resetn_r;
  logic [2:0]  m_req_r, m_wr_r, m_addr_ok_r, m_data_ok_r;
  logic [5:0]  m_size_r;
  logic [11:0] m_wstrb_r;
  logic [95:0] m_addr_r, m_wdata_r, m_rdata_r;
  logic        s_req_r, s_wr_r, s_addr_ok_r, s_data_ok_r, err_r;
  logic [1:0]  s_size_r;
  logic [3:0]  s_wstrb_r;
  logic [31:0] s_addr_r, s_wdata_r, s_rdata_r;

  sram_like_arb #(.NUM_M(2), .MAX_OUTST(4), .ARB_MODE(0)) u_fix (
    .clk(clk), .resetn(resetn_f), .m_req(m_req_f), .m_wr(m_wr_f), .m_size(m_size_f),
    .m_wstrb(m_wstrb_f), .m_addr(m_addr_f), .m_wdata(m_wdata_f), .m_addr_ok(m_addr_ok_f),
    .m_data_ok(m_data_ok_f), .m_rdata(m_rdata_f), .s_req(s_req_f), .s_wr(s_wr_f),
    .s_size(s_size_f), .s_wstrb(s_wstrb_f), .s_addr(s_addr_f), .s_wdata(s_wdata_f),
    .s_addr_ok(s_addr_ok_f), .s_data_ok(s_data_ok_f), .s_rdata(s_rdata_f), .err(err_f)
  );

  sram_like_arb #(.NUM_M(3), .MAX_OUTST(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .resetn(resetn_r), .m_req(m_req_r), .m_wr(m_wr_r), .m_size(m_size_r),
    .m_wstrb(m_wstrb_r), .m_addr(m_addr_r), .m_wdata(m_wdata_r), .m_addr_ok(m_addr_ok_r),
    .m_data_ok(m_data_ok_r), .m_rdata(m_rdata_r), .s_req(s_req_r), .s_wr(s_wr_r),
    .s_size(s_size_r), .s_wstrb(s_wstrb_r), .s_addr(s_addr_r), .s_wdata(s_wdata_r),
    .s_addr_ok(s_addr_ok_r), .s_data_ok(s_data_ok_r), .s_rdata(s_rdata_r), .err(err_r)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- fixed-priority instance ----------------
  typedef struct {
    logic [1:0] req;
    logic       aok;
    logic       dok;
    logic       sreq;
    logic [1:0] eaok;
    logic [1:0] edok;
    int         g;
  } vec_t;

  vec_t tbl[17];

  task automatic reset_f();
    resetn_f = 1'b0; m_req_f = 2'b11; s_addr_ok_f = 1'b1; s_data_ok_f = 1'b1;
    tick(); tick();
    #2;
    chk("rst_f s_req", s_req_f, 1'b0);
    chk("rst_f addr_ok", m_addr_ok_f, 2'b00);
    chk("rst_f data_ok", m_data_ok_f, 2'b00);
    tick();
    resetn_f = 1'b1; s_data_ok_f = 1'b0; m_req_f = 2'b00;
  endtask

  task automatic fcyc(input string nm, input logic [1:0] req, input logic aok, input logic dok,
                      input logic [31:0] rd, input logic e_sreq, input logic [1:0] e_aok,
                      input logic [1:0] e_dok, input logic e_err, input int g);
    m_req_f = req; s_addr_ok_f = aok; s_data_ok_f = dok; s_rdata_f = rd;
    #2;
    chk({nm, " s_req"}, s_req_f, e_sreq);
    chk({nm, " addr_ok"}, m_addr_ok_f, e_aok);
    chk({nm, " data_ok"}, m_data_ok_f, e_dok);
    chk({nm, " rdata"}, m_rdata_f, {2{rd}});
    chk({nm, " err"}, err_f, e_err);
    if (g >= 0)
      chk({nm, " fields"}, {s_wr_f, s_size_f, s_wstrb_f, s_addr_f, s_wdata_f},
          {m_wr_f[g], m_size_f[g*2 +: 2], m_wstrb_f[g*4 +: 4], m_addr_f[g*32 +: 32], m_wdata_f[g*32 +: 32]});
    tick();
  endtask

  // ---------------- round-robin reference model ----------------
  logic [1:0] exp_q[$];
  int         mdl_last;
  bit         mdl_locked;
  int         mdl_lock_idx;
  bit         mdl_err;
  bit         mdl_fresh;

  function automatic int mdl_grant(input logic [2:0] req);
    int start;
    if (mdl_locked) return mdl_lock_idx;
    start = (mdl_last < 0) ? 0 : (mdl_last + 1) % 3;
    for (int k = 0; k < 3; k++) begin
      if (((req >> ((start + k) % 3)) & 3'b001) != 3'b000) return (start + k) % 3;
    end
    return -1;
  endfunction

  task automatic rr_reset();
    resetn_r = 1'b0; m_req_r = 3'b111; s_addr_ok_r = 1'b1; s_data_ok_r = 1'b1;
    tick(); tick();
    #2;
    chk("rst_r s_req", s_req_r, 1'b0);
    chk("rst_r addr_ok", m_addr_ok_r, 3'b000);
    chk("rst_r data_ok", m_data_ok_r, 3'b000);
    tick();
    resetn_r = 1'b1; s_data_ok_r = 1'b0; m_req_r = 3'b000;
    exp_q.delete();
    mdl_last = -1; mdl_locked = 0; mdl_lock_idx = 0; mdl_err = 0; mdl_fresh = 1;
  endtask

  task automatic rr_cycle(input logic [2:0] req, input logic aok, input logic dok, input logic rnd,
                          output logic [2:0] got_aok, output logic [31:0] got_addr);
    int g;
    logic e_sreq;
    logic [2:0] e_aok, e_dok;
    m_req_r = req; s_addr_ok_r = aok; s_data_ok_r = dok; s_rdata_r = $urandom;
    if (rnd) begin
      m_addr_r = {$urandom, $urandom, $urandom};
      m_wdata_r = {$urandom, $urandom, $urandom};
      m_wr_r = 3'($urandom_range(0, 7));
      m_size_r = 6'($urandom_range(0, 63));
      m_wstrb_r = 12'($urandom_range(0, 4095));
    end
    g = mdl_grant(req);
    e_sreq = !mdl_fresh && g >= 0 && (((req >> g) & 3'b001) != 3'b000) && exp_q.size() < 4;
    e_aok = (e_sreq && aok) ? 3'(1 << g) : 3'b000;
    e_dok = (dok && exp_q.size() > 0) ? 3'(1 << exp_q[0]) : 3'b000;
    #2;
    chk("rr s_req", s_req_r, e_sreq);
    chk("rr addr_ok", m_addr_ok_r, e_aok);
    chk("rr data_ok", m_data_ok_r, e_dok);
    chk("rr rdata", m_rdata_r, {3{s_rdata_r}});
    chk("rr err", err_r, mdl_err);
    if (g >= 0)
      chk("rr fields", {s_wr_r, s_size_r, s_wstrb_r, s_addr_r, s_wdata_r},
          {m_wr_r[g], m_size_r[g*2 +: 2], m_wstrb_r[g*4 +: 4], m_addr_r[g*32 +: 32], m_wdata_r[g*32 +: 32]});
    got_aok = m_addr_ok_r;
    got_addr = s_addr_r;
    tick();
    if (dok && e_dok == 3'b000) mdl_err = 1;
    if (e_dok != 3'b000) void'(exp_q.pop_front());
    if (e_aok != 3'b000) begin
      exp_q.push_back(2'(g));
      mdl_last = g;
      mdl_locked = 0;
    end else if (e_sreq) begin
      mdl_locked = 1;
      mdl_lock_idx = g;
    end
    mdl_fresh = 0;
  endtask

  initial begin
    logic [2:0]  ga;
    logic [31:0] gaddr, held_addr;

    resetn_f = 1'b0; resetn_r = 1'b0;
    m_req_f = '0; s_addr_ok_f = 1'b0; s_data_ok_f = 1'b0; s_rdata_f = '0;
    m_addr_f = {32'h2000_0020, 32'h1000_0010};
    m_wdata_f = {32'hB1B1_0001, 32'hA0A0_0000};
    m_wr_f = 2'b10; m_size_f = 4'b0110; m_wstrb_f = 8'hCF;
    m_req_r = '0; s_addr_ok_r = 1'b0; s_data_ok_r = 1'b0; s_rdata_r = '0;
    m_addr_r = '0; m_wdata_r = '0; m_wr_r = '0; m_size_r = '0; m_wstrb_r = '0;
    mdl_last = -1; mdl_locked = 0; mdl_lock_idx = 0; mdl_err = 0; mdl_fresh = 1;

    //             req    aok   dok   sreq  eaok   edok   g
    tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 0};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 0};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 0};
    tbl[3]  = '{2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1};
    tbl[4]  = '{2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 0};
    tbl[5]  = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 0};
    tbl[6]  = '{2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 1};
    tbl[7]  = '{2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1};
    tbl[8]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1};
    tbl[9]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 0};
    tbl[10] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 0};
    tbl[11] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 0};
    tbl[12] = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 0};
    tbl[13] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, -1};
    tbl[14] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, -1};
    tbl[15] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, -1};
    tbl[16] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, -1};

    // Fixed priority, lock without preemption, full/pop interplay
    reset_f();
    for (int i = 0; i < 17; i++)
      fcyc($sformatf("tbl%0d", i), tbl[i].req, tbl[i].aok, tbl[i].dok, $urandom,
           tbl[i].sreq, tbl[i].eaok, tbl[i].edok, 1'b0, tbl[i].g);

    // Out-of-order owners: M1 then M0, responses routed back in that order
    reset_f();
    fcyc("ord idle", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    fcyc("ord m1", 2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00, 1'b0, 1);
    fcyc("ord m0", 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 1'b0, 0);
    fcyc("ord rsp1", 2'b00, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 2'b00, 2'b10, 1'b0, -1);
    fcyc("ord rsp0", 2'b00, 1'b0, 1'b1, 32'h5555_0002, 1'b0, 2'b00, 2'b01, 1'b0, -1);

    // Four outstanding reads fill the FIFO; request resumes the cycle after a pop
    reset_f();
    fcyc("full idle", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    for (int i = 0; i < 4; i++)
      fcyc($sformatf("full acc%0d", i), 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 1'b0, 0);
    fcyc("full hold", 2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 0);
    fcyc("full pop", 2'b01, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 2'b00, 2'b01, 1'b0, 0);
    fcyc("full resume", 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      fcyc($sformatf("full drain%0d", i), 2'b00, 1'b0, 1'b1, $urandom, 1'b0, 2'b00, 2'b01, 1'b0, -1);

    // Push and pop together at count 2, then a stray response sets err
    reset_f();
    fcyc("pp idle", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    fcyc("pp a1", 2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00, 1'b0, 1);
    fcyc("pp a0", 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 1'b0, 0);
    fcyc("pp both", 2'b10, 1'b1, 1'b1, 32'h0, 1'b1, 2'b10, 2'b10, 1'b0, 1);
    fcyc("pp r0", 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 2'b00, 2'b01, 1'b0, -1);
    fcyc("pp r1", 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 2'b00, 2'b10, 1'b0, -1);
    fcyc("pp stray", 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    for (int i = 0; i < 3; i++)
      fcyc($sformatf("pp sticky%0d", i), 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1, -1);
    reset_f();
    fcyc("pp cleared", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, -1);

    // Reset with a transaction outstanding drops its ID
    fcyc("mid acc", 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 1'b0, 0);
    reset_f();
    fcyc("mid rsp", 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    fcyc("mid err", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1, -1);
    reset_f();

    // Round-robin rotation and grant lock
    rr_reset();
    rr_cycle(3'b000, 1'b0, 1'b0, 1'b1, ga, gaddr);
    rr_cycle(3'b111, 1'b1, 1'b0, 1'b0, ga, gaddr); chk("rr seq g0", ga, 3'b001);
    rr_cycle(3'b111, 1'b1, 1'b1, 1'b0, ga, gaddr); chk("rr seq g1", ga, 3'b010);
    rr_cycle(3'b111, 1'b1, 1'b1, 1'b0, ga, gaddr); chk("rr seq g2", ga, 3'b100);
    rr_cycle(3'b111, 1'b1, 1'b1, 1'b0, ga, gaddr); chk("rr seq g3", ga, 3'b001);
    held_addr = m_addr_r[95:64];
    rr_cycle(3'b100, 1'b0, 1'b1, 1'b0, ga, gaddr);
    chk("rr lock ok0", ga, 3'b000); chk("rr lock addr0", gaddr, held_addr);
    rr_cycle(3'b111, 1'b0, 1'b0, 1'b0, ga, gaddr);
    chk("rr lock ok1", ga, 3'b000); chk("rr lock addr1", gaddr, held_addr);
    rr_cycle(3'b111, 1'b0, 1'b0, 1'b0, ga, gaddr);
    chk("rr lock ok2", ga, 3'b000); chk("rr lock addr2", gaddr, held_addr);
    rr_cycle(3'b111, 1'b1, 1'b0, 1'b0, ga, gaddr); chk("rr lock release", ga, 3'b100);
    rr_cycle(3'b111, 1'b1, 1'b0, 1'b0, ga, gaddr); chk("rr after lock", ga, 3'b001);

    // Random traffic against the model
    rr_reset();
    for (int n = 0; n < 800; n++) begin
      logic [2:0] rq;
      logic a, d;
      if ($urandom_range(0, 99) == 0) begin
        rr_reset();
        continue;
      end
      rq = 3'($urandom_range(0, 7));
      if (mdl_locked) rq = rq | 3'(1 << mdl_lock_idx);
      a = ($urandom_range(0, 2) != 0);
      d = (exp_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 59) == 0);
      rr_cycle(rq, a, d, 1'b1, ga, gaddr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
